// File: rtl/mem_access_unit.sv
// mem_access_unit: ME-stage load/store bus master (IDLE/BUSY/DONE); define MAU_TIMEOUT_EN for a BUSY-cycle ack timeout.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReq,
  input  logic        iWe,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  input  logic        iFlush,
  output logic        oStall,
  output logic [31:0] oRData,
  output logic        oRValid,
  output logic        oFault,
  output logic [1:0]  oFaultCause,
  output logic        oBusReq,
  output logic        oBusWe,
  output logic [31:0] oBusAddr,
  output logic [3:0]  oBusBe,
  output logic [31:0] oBusWData,
  input  logic        iBusAck,
  input  logic [31:0] iBusRData,
  input  logic        iBusErr
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [2:0] f3;
  logic [1:0] lane;
  logic flushed, valid_q, fault_q, illegal, misalign, flush_now, tmo;
  logic [3:0] be;
  logic [31:0] wd, sh, ld;
  always_comb begin
    illegal = iFunct3 == 3'b011 || iFunct3[2:1] == 2'b11 || (iWe && iFunct3[2]);
    misalign = (iFunct3[1:0] == 2'b01 && iAddr[0]) || (iFunct3[1:0] == 2'b10 && iAddr[1:0] != 2'b00);
    be = iFunct3[1:0] == 2'b00 ? 4'b0001 << iAddr[1:0] : iFunct3[1:0] == 2'b01 ? 4'b0011 << iAddr[1:0] : 4'b1111;
    wd = iFunct3[1:0] == 2'b00 ? {4{iWData[7:0]}} : iFunct3[1:0] == 2'b01 ? {2{iWData[15:0]}} : iWData;
    sh = iBusRData >> {lane, 3'b000};
    ld = f3 == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
         f3 == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
         f3 == 3'b100 ? {24'b0, sh[7:0]} :
         f3 == 3'b101 ? {16'b0, sh[15:0]} : iBusRData;
    flush_now = flushed | iFlush;
  end
`ifdef MAU_TIMEOUT_EN
  localparam int CW = TIMEOUT_CYCLES > 255 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt;
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) cnt <= '0;
    else cnt <= state == BUSY ? cnt + 1'b1 : '0;
`else
  assign tmo = 1'b0;
`endif
  assign oStall = ~iRst & ((state == IDLE && iReq && !iFlush) || state == BUSY);
  assign oRValid = valid_q & ~iFlush;
  assign oFault = fault_q & ~iFlush;
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= IDLE;
      {f3, lane, flushed, valid_q, fault_q, oFaultCause, oRData} <= '0;
      {oBusReq, oBusWe, oBusAddr, oBusBe, oBusWData} <= '0;
    end else begin
      case (state)
        IDLE: if (iReq && !iFlush) begin
          f3 <= iFunct3;
          lane <= iAddr[1:0];
          flushed <= 1'b0;
          if (illegal || misalign) begin
            state <= DONE;
            fault_q <= 1'b1;
            oFaultCause <= illegal ? 2'b11 : 2'b00;
          end else begin
            state <= BUSY;
            oBusReq <= 1'b1;
            oBusWe <= iWe;
            oBusAddr <= {iAddr[31:2], 2'b00};
            oBusBe <= be;
            oBusWData <= wd;
          end
        end
        BUSY: begin
          flushed <= flush_now;
          if (iBusAck) begin
            state <= DONE;
            oBusReq <= 1'b0;
            oRData <= ld;
            valid_q <= !flush_now && !iBusErr && !oBusWe;
            fault_q <= !flush_now && iBusErr;
            oFaultCause <= 2'b01;
          end else if (tmo) begin
            state <= DONE;
            oBusReq <= 1'b0;
            fault_q <= !flush_now;
            oFaultCause <= 2'b10;
          end
        end
        default: begin
          state <= IDLE;
          valid_q <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit; set MAU_TIMEOUT_EN to exercise the ack timeout.
module tb_mem_access_unit;
`ifdef MAU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif
  logic iClk = 0, iRst, iReq, iWe, iFlush, iBusAck, iBusErr;
  logic [2:0] iFunct3;
  logic [31:0] iAddr, iWData, iBusRData;
  logic oStall, oRValid, oFault, oBusReq, oBusWe;
  logic [1:0] oFaultCause;
  logic [31:0] oRData, oBusAddr, oBusWData;
  logic [3:0] oBusBe;
  int checks = 0, errors = 0, stalls;
  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iWe(iWe), .iFunct3(iFunct3), .iAddr(iAddr),
    .iWData(iWData), .iFlush(iFlush), .oStall(oStall), .oRData(oRData), .oRValid(oRValid),
    .oFault(oFault), .oFaultCause(oFaultCause), .oBusReq(oBusReq), .oBusWe(oBusWe),
    .oBusAddr(oBusAddr), .oBusBe(oBusBe), .oBusWData(oBusWData), .iBusAck(iBusAck),
    .iBusRData(iBusRData), .iBusErr(iBusErr)
  );
  always #5 iClk = ~iClk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge iClk);
    #1;
  endtask
  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    iReq = 1; iWe = we; iFunct3 = f3; iAddr = a; iWData = d;
    #1;
  endtask
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp_d, input logic [3:0] exp_be);
    req(0, f3, a, 0);
    chk({tag, "_stall_req"}, oStall, 1);
    tick;
    iReq = 0;
    chk({tag, "_busreq"}, oBusReq, 1);
    chk({tag, "_be"}, oBusBe, exp_be);
    chk({tag, "_addr"}, oBusAddr, {a[31:2], 2'b00});
    iBusAck = 1; iBusRData = rd;
    tick;
    iBusAck = 0;
    chk({tag, "_rvalid"}, oRValid, 1);
    chk({tag, "_rdata"}, oRData, exp_d);
    chk({tag, "_stall_done"}, oStall, 0);
    tick;
    chk({tag, "_rvalid_pulse"}, oRValid, 0);
  endtask
  initial begin
    iRst = 1; iReq = 0; iWe = 0; iFunct3 = 0; iAddr = 0; iWData = 0;
    iFlush = 0; iBusAck = 0; iBusErr = 0; iBusRData = 0;
    #12;
    chk("rst_busreq", oBusReq, 0);
    chk("rst_stall", oStall, 0);
    chk("rst_rvalid", oRValid, 0);
    chk("rst_fault", oFault, 0);
    @(negedge iClk);
    iRst = 0;
    tick;
    do_load("lb", 3'b000, 32'h1003, 32'h80FF_FF00, 32'hFFFF_FF80, 4'b1000);
    do_load("lhu", 3'b101, 32'h6002, 32'h8001_2345, 32'h0000_8001, 4'b1100);
    do_load("lh", 3'b001, 32'h6000, 32'h1234_8765, 32'hFFFF_8765, 4'b0011);
    do_load("lbu", 3'b100, 32'h6001, 32'h0000_F000, 32'h0000_00F0, 4'b0010);
    do_load("lw", 3'b010, 32'h7000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111);
    req(1, 3'b001, 32'h2002, 32'h0000_ABCD);
    tick;
    iReq = 0;
    chk("sh_be", oBusBe, 4'b1100);
    chk("sh_wdata", oBusWData, 32'hABCD_ABCD);
    chk("sh_we", oBusWe, 1);
    iBusAck = 1;
    tick;
    iBusAck = 0;
    chk("sh_rvalid", oRValid, 0);
    chk("sh_fault", oFault, 0);
    tick;
    req(0, 3'b010, 32'h3001, 0);
    chk("mis_stall", oStall, 1);
    tick;
    iReq = 0;
    chk("mis_busreq", oBusReq, 0);
    chk("mis_stall_done", oStall, 0);
    chk("mis_fault", oFault, 1);
    chk("mis_cause", oFaultCause, 2'b00);
    tick;
    chk("mis_fault_pulse", oFault, 0);
    req(1, 3'b100, 32'h3000, 0);
    tick;
    iReq = 0;
    chk("ill_busreq", oBusReq, 0);
    chk("ill_fault", oFault, 1);
    chk("ill_cause", oFaultCause, 2'b11);
    tick;
    req(0, 3'b010, 32'h4000, 0);
    stalls = int'(oStall);
    for (int k = 1; k <= 5; k++) begin
      tick;
      iReq = 0;
      stalls += int'(oStall);
      iFlush = (k == 2);
      iBusAck = (k == 5);
    end
    tick;
    iBusAck = 0;
    stalls += int'(oStall);
    chk("flb_stalls", stalls, 6);
    chk("flb_rvalid", oRValid, 0);
    chk("flb_fault", oFault, 0);
    tick;
    chk("flb_idle_busreq", oBusReq, 0);
    req(0, 3'b001, 32'h5002, 0);
    tick;
    iReq = 0; iBusAck = 1; iBusErr = 1;
    tick;
    iBusAck = 0; iBusErr = 0;
    chk("err_fault", oFault, 1);
    chk("err_cause", oFaultCause, 2'b01);
    chk("err_rvalid", oRValid, 0);
    tick;
    req(0, 3'b000, 32'h1000, 0);
    iFlush = 1;
    #1;
    chk("fli_stall", oStall, 0);
    tick;
    iReq = 0; iFlush = 0;
    chk("fli_busreq", oBusReq, 0);
    req(0, 3'b000, 32'h1000, 0);
    tick;
    iReq = 0; iBusAck = 1; iBusRData = 32'h0000_0011;
    tick;
    iBusAck = 0; iFlush = 1;
    #1;
    chk("fld_rvalid", oRValid, 0);
    tick;
    iFlush = 0;
    req(0, 3'b010, 32'h8000, 0);
    tick;
    chk("rst_busy_busreq_pre", oBusReq, 1);
    iRst = 1;
    #1;
    chk("rst_busy_busreq", oBusReq, 0);
    chk("rst_busy_stall", oStall, 0);
    @(negedge iClk);
    iRst = 0; iReq = 0;
    tick;
    chk("rst_after_busreq", oBusReq, 0);
    req(0, 3'b010, 32'h9000, 0);
    tick;
    iReq = 0;
`ifdef MAU_TIMEOUT_EN
    for (int k = 1; k < 4; k++) begin
      tick;
      chk("to_busy", oBusReq, 1);
    end
    tick;
    chk("to_busreq", oBusReq, 0);
    chk("to_fault", oFault, 1);
    chk("to_cause", oFaultCause, 2'b10);
`else
    repeat (10) tick;
    chk("noto_busreq", oBusReq, 1);
    chk("noto_stall", oStall, 1);
    iBusAck = 1; iBusRData = 32'h1234_5678;
    tick;
    iBusAck = 0;
    chk("noto_rdata", oRData, 32'h1234_5678);
`endif
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of BUSY cycles waited for iBusAck (used only with MAU_TIMEOUT_EN).
REQ-002 SHALL have port iClk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port iRst, input, 1, the reset: asynchronous assertion, active-high.
REQ-004 SHALL have port iReq, input, 1, ME-stage instruction is a load/store (ctrl.mem_en).
REQ-005 SHALL have port iWe, input, 1, 1=store, 0=load.
REQ-006 SHALL have port iFunct3, input, 3, RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port iAddr, input, 32, effective byte address.
REQ-008 SHALL have port iWData, input, 32, store data (rs2).
REQ-009 SHALL have port iFlush, input, 1, discard current ME request/result.
REQ-010 SHALL have port oStall, output, 1, stall request to the hazard unit (drives its iStall_ME).
REQ-011 SHALL have port oRData, output, 32, extended load result.
REQ-012 SHALL have port oRValid, output, 1, oRData valid (one-cycle pulse).
REQ-013 SHALL have port oFault, output, 1, access fault (one-cycle pulse).
REQ-014 SHALL have port oFaultCause, output, 2, 00 misalign, 01 bus error, 10 timeout, 11 illegal funct3.
REQ-015 SHALL have ports oBusReq/oBusWe (output, 1), oBusAddr (output, 32), oBusBe (output, 4), oBusWData (output, 32): registered bus request.
REQ-016 SHALL have ports iBusAck (input, 1), iBusRData (input, 32), iBusErr (input, 1): bus response, sampled while oBusReq=1.

Function
REQ-017 SHALL implement FSM IDLE, BUSY, DONE.
REQ-018 IDLE: iReq=1 and iFlush=0 -> oStall=1 combinationally; legal access -> BUSY with bus outputs registered; misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0) or illegal funct3 -> DONE with fault latched, no bus cycle.
REQ-019 BUSY: oBusReq=1, bus outputs held constant, oStall=1; iBusAck=1 -> DONE, capture iBusRData/iBusErr, oBusReq=0 next cycle.
REQ-020 DONE: oStall=0 for exactly one cycle, oRValid=1 for successful loads, oFault=1 if a fault was latched; the pipeline advances on that edge; next state IDLE unconditionally (same instruction never reissued).
REQ-021 Minimum load latency: request cycle N, oBusReq at N+1, ack at N+1 -> DONE at N+2 (oStall high N..N+1).
REQ-022 oBusAddr = {iAddr[31:2],2'b00}; oBusBe = 0001<<addr[1:0] (B), 0011<<addr[1:0] (H), 1111 (W); oBusWData = byte/half replicated across lanes.
REQ-023 Load lane selected by addr[1:0]; B/H sign-extended, BU/HU zero-extended, W unmodified.
REQ-024 iFlush in IDLE suppresses the request; iFlush in BUSY does not abort the bus cycle but the ack returns to IDLE with oRValid=0, oFault=0; iFlush in DONE masks oRValid/oFault.
REQ-025 iBusErr=1 with iBusAck -> DONE with oFault=1, cause 01, oRValid=0.

Reset
REQ-026 iRst asynchronously forces IDLE and all outputs to 0, including mid-transaction (oBusReq drops immediately).
REQ-027 First rising edge after iRst deasserts SHALL be evaluated in IDLE.

Configuration
REQ-028 Macro MAU_TIMEOUT_EN defined: 8-bit-or-wider BUSY-cycle counter, cleared on BUSY entry; reaching TIMEOUT_CYCLES without ack drops oBusReq -> DONE with oFault=1, cause 10. Undefined: no counter, BUSY waits indefinitely, cause 10 never produced.

Verification
REQ-029 LB addr 0x1003, bus data 0x80FF_FF00 -> oBusBe=1000, oRData=0xFFFF_FF80, oRValid after ack.
REQ-030 SH addr 0x2002, iWData 0x0000_ABCD -> oBusBe=1100, oBusWData=0xABCD_ABCD, oBusWe=1.
REQ-031 LW addr 0x3001 -> no oBusReq, oStall high 1 cycle, oFault=1, cause 00.
REQ-032 LW with ack delayed 5 cycles, iFlush pulsed in BUSY -> oStall 6 cycles, oRValid=0, return to IDLE.
REQ-033 iRst asserted in BUSY -> oBusReq=0 and oStall=0 immediately; with MAU_TIMEOUT_EN, TIMEOUT_CYCLES=4 and no ack -> oFault cause 10 after 4 BUSY cycles.
